// File: rtl/score_bcd_driver.sv
// Pong scoreboard: packed-BCD scores, win detect, winner digit flash and leading-zero blanking.
// Latency: 1 cycle from point/clear to outputs; no backpressure, pulses are always accepted in PLAY.
module score_bcd_driver #(
  parameter int WIN_SCORE = 11,
  parameter int FLASH_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       clear,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic [3:0] blank,
  output logic       game_over,
  output logic       winner
);

  localparam int CNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_DIV - 1);

  typedef enum logic {PLAY = 1'b0, WON = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       p1_q, p1_d, p2_q, p2_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       p1_inc, p2_inc;
  logic             win1, win2;
  logic             flash_blank;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign p1_inc = bcd_inc(p1_q);
  assign p2_inc = bcd_inc(p2_q);
  assign win1   = point_p1 && (p1_inc == WIN_BCD);
  assign win2   = point_p2 && (p2_inc == WIN_BCD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PLAY;
      p1_q     <= 8'h00;
      p2_q     <= 8'h00;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (clear) begin
      state_d  = PLAY;
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      winner_d = 1'b0;
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          cnt_d   = '0;
          phase_d = 1'b1;
          if (point_p1) p1_d = p1_inc;
          if (point_p2) p2_d = p2_inc;
          // A simultaneous double win goes to player 1.
          if (win1 || win2) begin
            state_d  = WON;
            winner_d = !win1;
          end
        end
        WON: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = !phase_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = PLAY;
      endcase
    end
  end

  assign flash_blank = (state_q == WON) && !phase_q;

  assign p1_tens   = p1_q[7:4];
  assign p1_ones   = p1_q[3:0];
  assign p2_tens   = p2_q[7:4];
  assign p2_ones   = p2_q[3:0];
  assign game_over = (state_q == WON);
  assign winner    = winner_q;

  assign blank[3] = (p1_q[7:4] == 4'd0) || (flash_blank && !winner_q);
  assign blank[2] = flash_blank && !winner_q;
  assign blank[1] = (p2_q[7:4] == 4'd0) || (flash_blank && winner_q);
  assign blank[0] = flash_blank && winner_q;

endmodule
